// File: rtl/aes_output_buffer.sv
// AES result serialiser: captures DATA_W on done_i, emits NWORDS words LSW first (valid/ready).
// Latency: done_i in cycle N -> word0 valid in cycle N+1; words advance one per accepted transfer.
// Backpressure: words hold while ready_i=0; busy_o flags a slot that cannot take done_i, drops set ovf_o.
// Optional AES_OUT_DBLBUF_EN: adds a one-block pending register for back-to-back blocks.
module aes_output_buffer #(
    parameter int DATA_W = 128,
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              done_i,
    input  logic [DATA_W-1:0] text_i,
    input  logic              ready_i,
    output logic [WORD_W-1:0] text_o,
    output logic              valid_o,
    output logic              last_o,
    output logic              busy_o,
    output logic              ovf_o
);

    localparam int NWORDS = DATA_W / WORD_W;
    localparam int CNT_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NWORDS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic                last_q, last_d;
    logic                ovf_q, ovf_d;

    logic                xfer;
    logic                at_last;
    logic                busy;

`ifdef AES_OUT_DBLBUF_EN
    logic [DATA_W-1:0]   pend_q, pend_d;
    logic                pend_vld_q, pend_vld_d;
`endif

    assign xfer    = (state_q == SEND) && ready_i;
    assign at_last = (state_q == SEND) && (cnt_q == CNT_LAST);

`ifdef AES_OUT_DBLBUF_EN
    // Only a full pending slot blocks, unless it drains into shift this cycle.
    assign busy = pend_vld_q && !(xfer && at_last);
`else
    assign busy = (state_q == SEND) && !(xfer && at_last);
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        ovf_d   = ovf_q | (done_i & busy);
`ifdef AES_OUT_DBLBUF_EN
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
`endif

        case (state_q)
            IDLE: begin
                if (done_i) begin
                    shift_d = text_i;
                    cnt_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (xfer && !at_last) begin
                    shift_d = shift_q >> WORD_W;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
`ifdef AES_OUT_DBLBUF_EN
                if (xfer && at_last) begin
                    if (pend_vld_q) begin
                        shift_d    = pend_q;
                        cnt_d      = '0;
                        pend_vld_d = done_i;
                        if (done_i) begin
                            pend_d = text_i;
                        end
                    end else if (done_i) begin
                        shift_d = text_i;
                        cnt_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (done_i && !pend_vld_q) begin
                    pend_d     = text_i;
                    pend_vld_d = 1'b1;
                end
`else
                if (xfer && at_last) begin
                    if (done_i) begin
                        shift_d = text_i;
                        cnt_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
`endif
            end
            default: state_d = IDLE;
        endcase

        last_d = (state_d == SEND) && (cnt_d == CNT_LAST);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            last_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            last_q  <= last_d;
            ovf_q   <= ovf_d;
        end
    end

`ifdef AES_OUT_DBLBUF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
        end else begin
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
        end
    end
`endif

    assign text_o  = shift_q[WORD_W-1:0];
    assign valid_o = (state_q == SEND);
    assign last_o  = last_q;
    assign busy_o  = busy;
    assign ovf_o   = ovf_q;

endmodule

// File: tb/tb_aes_output_buffer.sv
// Directed bench for aes_output_buffer: serial order, stall hold, overflow, back-to-back, async reset.
module tb_aes_output_buffer;

    logic         clk;
    logic         rst;
    logic         done_i;
    logic [127:0] text_i;
    logic         ready_i;
    logic [31:0]  text_o;
    logic         valid_o;
    logic         last_o;
    logic         busy_o;
    logic         ovf_o;

    int checks = 0;
    int errors = 0;

    logic [127:0] blk_a = 128'h33333333_22222222_11111111_00000000;
    logic [127:0] blk_b = 128'h77777777_66666666_55555555_44444444;
    logic [127:0] blk_c = 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0;

    aes_output_buffer #(.DATA_W(128), .WORD_W(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .done_i  (done_i),
        .text_i  (text_i),
        .ready_i (ready_i),
        .text_o  (text_o),
        .valid_o (valid_o),
        .last_o  (last_o),
        .busy_o  (busy_o),
        .ovf_o   (ovf_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_word(input string tag, input logic [127:0] blk, input int idx);
        chk({tag, "_valid"}, {31'd0, valid_o}, 32'd1);
        chk({tag, "_text"}, text_o, blk[idx*32 +: 32]);
        chk({tag, "_last"}, {31'd0, last_o}, {31'd0, idx == 3});
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #3;
        rst = 1'b1;
        cyc();
    endtask

    initial begin
        rst     = 1'b0;
        done_i  = 1'b0;
        text_i  = '0;
        ready_i = 1'b0;
        #3;
        chk("rst_text",  text_o,            32'd0);
        chk("rst_valid", {31'd0, valid_o},  32'd0);
        chk("rst_last",  {31'd0, last_o},   32'd0);
        chk("rst_busy",  {31'd0, busy_o},   32'd0);
        chk("rst_ovf",   {31'd0, ovf_o},    32'd0);
        cyc();
        cyc();
        rst = 1'b1;
        cyc();

        // Plain stream with ready held high
        done_i = 1'b1; text_i = blk_a; ready_i = 1'b1;
        cyc();
        done_i = 1'b0; text_i = '0;
        for (int i = 0; i < 4; i++) begin
            chk_word($sformatf("t1_w%0d", i), blk_a, i);
            cyc();
        end
        chk("t1_idle_valid", {31'd0, valid_o}, 32'd0);

        // Stall: word0 must hold while ready_i=0
        done_i = 1'b1; text_i = blk_a; ready_i = 1'b0;
        cyc();
        done_i = 1'b0; text_i = '0;
        for (int i = 0; i < 3; i++) begin
            chk_word($sformatf("t2_hold%0d", i), blk_a, 0);
            cyc();
        end
        ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk_word($sformatf("t2_w%0d", i), blk_a, i);
            cyc();
        end
        chk("t2_idle_valid", {31'd0, valid_o}, 32'd0);

        // done_i on the last-word transfer: new block follows with no gap
        done_i = 1'b1; text_i = blk_a;
        cyc();
        done_i = 1'b0; text_i = '0;
        for (int i = 0; i < 8; i++) begin
            chk_word($sformatf("t4_w%0d", i), (i < 4) ? blk_a : blk_b, i % 4);
            if (i == 3) begin
                done_i = 1'b1; text_i = blk_b;
                #1;
                chk("t4_busy_last", {31'd0, busy_o}, 32'd0);
            end
            cyc();
            done_i = 1'b0; text_i = '0;
        end
        chk("t4_ovf", {31'd0, ovf_o}, 32'd0);
        chk("t4_idle_valid", {31'd0, valid_o}, 32'd0);

`ifdef AES_OUT_DBLBUF_EN
        // B arrives at A word1 and is queued; A then B back-to-back
        done_i = 1'b1; text_i = blk_a;
        cyc();
        done_i = 1'b0; text_i = '0;
        for (int i = 0; i < 8; i++) begin
            chk_word($sformatf("t5_w%0d", i), (i < 4) ? blk_a : blk_b, i % 4);
            if (i == 1) begin
                done_i = 1'b1; text_i = blk_b;
                #1;
                chk("t5_busy_free", {31'd0, busy_o}, 32'd0);
            end
            cyc();
            done_i = 1'b0; text_i = '0;
        end
        chk("t5_ovf_clean", {31'd0, ovf_o}, 32'd0);
        chk("t5_idle_valid", {31'd0, valid_o}, 32'd0);

        // A third block while pending is full is dropped
        done_i = 1'b1; text_i = blk_a;
        cyc();
        done_i = 1'b0; text_i = '0;
        for (int i = 0; i < 8; i++) begin
            chk_word($sformatf("t5c_w%0d", i), (i < 4) ? blk_a : blk_b, i % 4);
            if (i == 1) begin
                done_i = 1'b1; text_i = blk_b;
            end else if (i == 2) begin
                done_i = 1'b1; text_i = blk_c;
                #1;
                chk("t5c_busy_full", {31'd0, busy_o}, 32'd1);
            end
            cyc();
            done_i = 1'b0; text_i = '0;
            if (i == 2) chk("t5c_ovf_set", {31'd0, ovf_o}, 32'd1);
        end
        chk("t5c_idle_valid", {31'd0, valid_o}, 32'd0);
`else
        // Second done_i during word1 is dropped and flagged
        done_i = 1'b1; text_i = blk_a;
        cyc();
        done_i = 1'b0; text_i = '0;
        chk_word("t3_w0", blk_a, 0);
        cyc();
        chk_word("t3_w1", blk_a, 1);
        done_i = 1'b1; text_i = blk_b;
        #1;
        chk("t3_busy", {31'd0, busy_o}, 32'd1);
        cyc();
        done_i = 1'b0; text_i = '0;
        chk("t3_ovf", {31'd0, ovf_o}, 32'd1);
        chk_word("t3_w2", blk_a, 2);
        cyc();
        chk_word("t3_w3", blk_a, 3);
        cyc();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("t3_no_second%0d", i), {31'd0, valid_o}, 32'd0);
            cyc();
        end
        chk("t3_ovf_sticky", {31'd0, ovf_o}, 32'd1);
`endif

        do_reset();
        chk("rst2_ovf", {31'd0, ovf_o}, 32'd0);

        // Async reset during word2
        done_i = 1'b1; text_i = blk_a;
        cyc();
        done_i = 1'b0; text_i = '0;
        cyc();
        cyc();
        chk_word("t6_w2", blk_a, 2);
        #2;
        rst = 1'b0;
        #1;
        chk("t6_text",  text_o,           32'd0);
        chk("t6_valid", {31'd0, valid_o}, 32'd0);
        chk("t6_last",  {31'd0, last_o},  32'd0);
        chk("t6_busy",  {31'd0, busy_o},  32'd0);
        chk("t6_ovf",   {31'd0, ovf_o},   32'd0);
        cyc();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk($sformatf("t6_post%0d", i), {31'd0, valid_o}, 32'd0);
        end
        done_i = 1'b1; text_i = blk_b;
        cyc();
        done_i = 1'b0; text_i = '0;
        chk_word("t6_new_w0", blk_b, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
